// File: rtl/ysyx_24110015_ifu_pkg.sv
// Shared types and AXI encodings for the instruction fetch prefetch unit.
package ysyx_24110015_ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        R     = 2'd2,
        DRAIN = 2'd3
    } IfuState;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } IfuEntry;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle with 32-bit address/data; the fetch unit uses only the read channels.
interface axi_if;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/ysyx_24110015_sync_fifo.sv
// Single-clock FIFO with flush; the head word is read straight from storage registers
// and forced to zero while empty.
module ysyx_24110015_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           pushData_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           headData_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem_q [2**PTR_W];
    logic             doPop;

    assign doPop = pop_i && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({push_i, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign headData_o = (count_q != '0) ? mem_q[rdPtr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/ysyx_24110015_ifu_prefetch.sv
// Instruction prefetcher: issues boundary-aligned AXI read bursts into a small queue
// and discards in-flight beats after a redirect.
module ysyx_24110015_ifu_prefetch
    import ysyx_24110015_ifu_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          BURST_LEN = 4,
    parameter logic [31:0] RESET_PC  = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        inst_err,
    axi_if.master       axiif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    IfuState          state_q, state_d;
    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [31:0]      pendPc_q, pendPc_d;
    logic             redirPend_q, redirPend_d;
    logic [CNT_W-1:0] count;
    logic [31:0]      burstBeats;
    logic [31:0]      freeSlots;
    logic             push;
    logic             pop;
    IfuEntry          pushEntry;
    IfuEntry          headEntry;
    logic             unusedAxi;

    // Burst length stops at the next BURST_LEN-word boundary so no burst crosses a page.
    assign burstBeats = 32'(BURST_LEN) - ({2'b00, fetchPc_q[31:2]} & 32'(BURST_LEN - 1));
    assign freeSlots  = 32'(DEPTH) - 32'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetchPc_q   <= RESET_PC;
            pendPc_q    <= '0;
            redirPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetchPc_q   <= fetchPc_d;
            pendPc_q    <= pendPc_d;
            redirPend_q <= redirPend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetchPc_d   = fetchPc_q;
        pendPc_d    = pendPc_q;
        redirPend_d = redirPend_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetchPc_d = redirect_pc;
                end else if (freeSlots >= burstBeats) begin
                    state_d = AR;
                end
            end
            AR: begin
                if (redirect) begin
                    pendPc_d    = redirect_pc;
                    redirPend_d = 1'b1;
                end
                if (axiif.arready) begin
                    state_d     = (redirect || redirPend_q) ? DRAIN : R;
                    redirPend_d = 1'b0;
                end
            end
            R: begin
                if (redirect) begin
                    pendPc_d = redirect_pc;
                    if (axiif.rvalid && axiif.rlast) begin
                        state_d   = IDLE;
                        fetchPc_d = redirect_pc;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (axiif.rvalid) begin
                    push      = 1'b1;
                    fetchPc_d = fetchPc_q + 32'd4;
                    if (axiif.rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // The newest redirect wins, even one arriving with the final beat.
                if (redirect) begin
                    pendPc_d = redirect_pc;
                end
                if (axiif.rvalid && axiif.rlast) begin
                    state_d   = IDLE;
                    fetchPc_d = redirect ? redirect_pc : pendPc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign axiif.arvalid = (state_q == AR);
    assign axiif.araddr  = fetchPc_q;
    assign axiif.arlen   = 8'(burstBeats - 32'd1);
    assign axiif.arsize  = AXI_SIZE_4B;
    assign axiif.arburst = AXI_BURST_INCR;
    assign axiif.arid    = '0;
    assign axiif.rready  = 1'b1;

    assign axiif.awvalid = 1'b0;
    assign axiif.awaddr  = '0;
    assign axiif.awlen   = '0;
    assign axiif.awsize  = '0;
    assign axiif.awburst = '0;
    assign axiif.awid    = '0;
    assign axiif.wvalid  = 1'b0;
    assign axiif.wdata   = '0;
    assign axiif.wstrb   = '0;
    assign axiif.wlast   = 1'b0;
    assign axiif.bready  = 1'b0;

    assign unusedAxi = ^{axiif.rid, axiif.awready, axiif.wready,
                         axiif.bvalid, axiif.bresp, axiif.bid};

    assign pushEntry = '{pc: fetchPc_q, inst: axiif.rdata, err: (axiif.rresp != 2'b00)};
    assign pop       = out_valid && out_ready;

    ysyx_24110015_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(IfuEntry))
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pushData_i (pushEntry),
        .pop_i      (pop),
        .flush_i    (redirect),
        .headData_o (headEntry),
        .count_o    (count)
    );

    assign out_valid = (count != '0);
    assign inst      = headEntry.inst;
    assign pc_out    = headEntry.pc;
    assign inst_err  = headEntry.err;

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// Directed bench for the prefetcher: a scripted AXI slave feeds beats and a
// scoreboard checks every instruction handed to the decoder.
module tb_ysyx_24110015_ifu_prefetch;
    import ysyx_24110015_ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        outValid;
    logic        outReady;
    logic [31:0] inst;
    logic [31:0] pcOut;
    logic        instErr;
    logic [31:0] rPcs [4];

    int vectorsApplied = 0;
    int miscompares    = 0;
    IfuEntry expQ[$];

    axi_if axi();

    ysyx_24110015_ifu_prefetch #(
        .DEPTH     (4),
        .BURST_LEN (4),
        .RESET_PC  (32'h3000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .inst        (inst),
        .pc_out      (pcOut),
        .inst_err    (instErr),
        .axiif       (axi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirectPc  = '0;
        outReady    = 1'b1;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        axi.rlast   = 1'b0;
        axi.rid     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset arvalid", 32'(axi.arvalid), 32'd0);
        checkOutput("reset inst", inst, 32'd0);
        checkOutput("reset pc_out", pcOut, 32'd0);
        checkOutput("reset inst_err", 32'(instErr), 32'd0);
        checkOutput("reset rready", 32'(axi.rready), 32'd1);
        expQ.delete();
        rst = 1'b0;
    endtask

    task automatic applyArHandshake(input string tag, input logic [31:0] addr,
                                    input logic [7:0] len, input int hold,
                                    input logic redirInAr, input logic [31:0] redirTo);
        int waited = 0;
        @(negedge clk);
        while (!axi.arvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, " arvalid"}, 32'(axi.arvalid), 32'd1);
        checkOutput({tag, " araddr"}, axi.araddr, addr);
        checkOutput({tag, " arlen"}, 32'(axi.arlen), 32'(len));
        checkOutput({tag, " burst/size/id"}, 32'({axi.arburst, axi.arsize, axi.arid}),
                    32'({2'b01, 3'b010, 4'b0000}));
        if (redirInAr) begin
            redirect   = 1'b1;
            redirectPc = redirTo;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            redirect = 1'b0;
            checkOutput({tag, " held arvalid"}, 32'(axi.arvalid), 32'd1);
            checkOutput({tag, " held araddr"}, axi.araddr, addr);
            checkOutput({tag, " held arlen"}, 32'(axi.arlen), 32'(len));
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic applyBeats(input logic [31:0] base, input int n, input int errIdx,
                              input int keep, input logic [3:0] redirMask,
                              input logic [31:0] redirPcs [4]);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && redirMask[i-1]) begin
                checkOutput("flush empties queue", 32'(outValid), 32'd0);
            end
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(i * 4);
            axi.rresp  = (i == errIdx) ? 2'b10 : 2'b00;
            axi.rlast  = (i == n - 1);
            redirect   = redirMask[i];
            redirectPc = redirPcs[i];
            if (i < keep) begin
                expQ.push_back('{pc: base + 32'(i * 4), inst: base + 32'(i * 4),
                                 err: (i == errIdx)});
            end
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        redirect   = 1'b0;
        if (redirMask[n-1]) begin
            checkOutput("flush on last beat", 32'(outValid), 32'd0);
        end
    endtask

    task automatic drainScoreboard(input string tag);
        int waited = 0;
        while (expQ.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, " scoreboard drained"}, 32'(expQ.size()), 32'd0);
    endtask

    // Handshakes are judged just after the falling edge, when inputs for the next edge are settled.
    always @(negedge clk) begin
        IfuEntry e;
        #1;
        if (!rst && outValid && outReady) begin
            vectorsApplied++;
            assert (expQ.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL unexpected pop: observed pc %h expected none", pcOut);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("pop pc_out", pcOut, e.pc);
                checkOutput("pop inst", inst, e.inst);
                checkOutput("pop inst_err", 32'(instErr), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = '0;
        for (int i = 0; i < 4; i++) rPcs[i] = '0;

        // Sequential fetch from reset, with arready held off to check AR stability
        applyReset();
        applyArHandshake("seq", 32'h3000_0000, 8'd3, 2, 1'b0, 32'h0);
        applyBeats(32'h3000_0000, 4, -1, 4, 4'b0000, rPcs);
        drainScoreboard("seq");
        applyArHandshake("seq next", 32'h3000_0010, 8'd3, 0, 1'b0, 32'h0);

        // Redirect in IDLE to a mid-block address splits the first burst
        applyReset();
        redirect   = 1'b1;
        redirectPc = 32'h3000_0008;
        @(negedge clk);
        redirect = 1'b0;
        checkOutput("no AR on redirect cycle", 32'(axi.arvalid), 32'd0);
        applyArHandshake("split", 32'h3000_0008, 8'd1, 0, 1'b0, 32'h0);
        applyBeats(32'h3000_0008, 2, -1, 2, 4'b0000, rPcs);
        drainScoreboard("split");
        applyArHandshake("after split", 32'h3000_0010, 8'd3, 0, 1'b0, 32'h0);

        // Back-pressure: no new AR until a whole burst fits
        applyReset();
        outReady = 1'b0;
        applyArHandshake("fill", 32'h3000_0000, 8'd3, 0, 1'b0, 32'h0);
        applyBeats(32'h3000_0000, 4, -1, 4, 4'b0000, rPcs);
        repeat (4) begin
            @(negedge clk);
            checkOutput("full no AR", 32'(axi.arvalid), 32'd0);
        end
        checkOutput("full head pc", pcOut, 32'h3000_0000);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("count3 no AR", 32'(axi.arvalid), 32'd0);
        end
        checkOutput("head after pop", pcOut, 32'h3000_0004);
        outReady = 1'b1;
        drainScoreboard("fill");
        applyArHandshake("refill", 32'h3000_0010, 8'd3, 0, 1'b0, 32'h0);

        // Redirect on beat 2 discards the rest of the burst
        applyReset();
        applyArHandshake("mid", 32'h3000_0000, 8'd3, 0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) rPcs[i] = '0;
        rPcs[1] = 32'h8000_0000;
        applyBeats(32'h3000_0000, 4, -1, 1, 4'b0010, rPcs);
        applyArHandshake("mid redirect", 32'h8000_0000, 8'd3, 0, 1'b0, 32'h0);
        applyBeats(32'h8000_0000, 4, -1, 4, 4'b0000, rPcs);
        drainScoreboard("mid");

        // Successive redirects while draining: the last one wins
        applyReset();
        applyArHandshake("drain", 32'h3000_0000, 8'd3, 0, 1'b0, 32'h0);
        rPcs[0] = 32'h7000_0000;
        rPcs[1] = 32'h8000_0000;
        rPcs[2] = 32'h8000_0040;
        rPcs[3] = 32'h0;
        applyBeats(32'h3000_0000, 4, -1, 0, 4'b0111, rPcs);
        applyArHandshake("latest redirect", 32'h8000_0040, 8'd3, 0, 1'b0, 32'h0);
        applyBeats(32'h8000_0040, 4, -1, 4, 4'b0000, rPcs);
        drainScoreboard("drain");

        // Error response on beat 3 only
        applyReset();
        applyArHandshake("err", 32'h3000_0000, 8'd3, 0, 1'b0, 32'h0);
        applyBeats(32'h3000_0000, 4, 2, 4, 4'b0000, rPcs);
        drainScoreboard("err");

        // Redirect coinciding with rlast, to the last word of a block
        applyReset();
        applyArHandshake("rlast", 32'h3000_0000, 8'd3, 0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) rPcs[i] = '0;
        rPcs[3] = 32'h9000_000C;
        applyBeats(32'h3000_0000, 4, -1, 3, 4'b1000, rPcs);
        applyArHandshake("rlast redirect", 32'h9000_000C, 8'd0, 0, 1'b0, 32'h0);
        applyBeats(32'h9000_000C, 1, -1, 1, 4'b0000, rPcs);
        drainScoreboard("rlast");
        applyArHandshake("after rlast", 32'h9000_0010, 8'd3, 0, 1'b0, 32'h0);

        // Redirect while the AR is still waiting for arready
        applyReset();
        applyArHandshake("ar redirect", 32'h3000_0000, 8'd3, 2, 1'b1, 32'h4000_0004);
        applyBeats(32'h3000_0000, 4, -1, 0, 4'b0000, rPcs);
        checkOutput("ar redirect discarded", 32'(outValid), 32'd0);
        applyArHandshake("after ar redirect", 32'h4000_0004, 8'd2, 0, 1'b0, 32'h0);
        applyBeats(32'h4000_0004, 3, -1, 3, 4'b0000, rPcs);
        drainScoreboard("ar redirect");

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
